mux_nway_pipe: RTL and testbench

//  - Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
//  - Generalises the fixed 4:1 32-bit combinational mux used on datapath select points.
//  - Adds a 1-deep output register, an out-of-range select guard and an optional round-robin source mode.
//  - Sits between producer stages (e.g. writeback sources, forwarding paths) and a single consumer.

---
 rtl/mux_nway_pkg.sv | 24 ++
 rtl/mux_nway_pipe_rr_arbiter.sv | 35 +++
 rtl/mux_nway_pipe.sv | 127 ++++++++++++
 tb/tb_mux_nway_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nway_pkg.sv
// mux_nway_pkg
//   Shared definitions for the N-way registered multiplexer:
//   - MODE_FIXED / MODE_RR : values of the Mode input
//   - sel_t                : channel index type wide enough for up to 16 channels
//   - clog2                : ceiling log2 for sizing select fields
package mux_nway_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_IN = 16;

    typedef logic [3:0] sel_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nway_pipe_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first requesting channel
//   found scanning ptr+1, ptr+2, ... modulo NUM_IN, so the channel at ptr
//   has the lowest priority.
// Ports:
//   req     in   NUM_IN  request vector (one bit per channel)
//   ptr     in   SEL_W   index of the most recently granted channel
//   gnt_idx out  SEL_W   granted channel index (0 when nothing granted)
//   gnt_vld out  1       a channel was granted
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    // Scan distances from farthest to nearest; the last hit wins, which is
    // the nearest requester after ptr.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_IN; k >= 1; k--) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (req[j] && (j == (int'(ptr) + k) % NUM_IN)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mux_nway_pipe.sv
// mux_nway_pipe
//   N-input, WIDTH-bit multiplexer with a one-deep registered output and a
//   valid/ready handshake on every input and on the output. An out-of-range
//   select grants nothing. Optional round-robin source selection is built
//   only when MUX_NWAY_ROUND_ROBIN_EN is defined; otherwise Mode is ignored.
// Ports:
//   Clk        in   1             rising-edge clock
//   Rst_n      in   1             synchronous active-low reset
//   In         in   NUM_IN*WIDTH  packed inputs, channel i = In[i*WIDTH +: WIDTH]
//   In_valid   in   NUM_IN        per-channel valid
//   In_ready   out  NUM_IN        per-channel ready, one-hot or zero
//   Sel        in   SEL_W         channel select in fixed mode
//   Mode       in   1             0 fixed select, 1 round-robin (macro builds only)
//   Out        out  WIDTH         registered selected word
//   Out_valid  out  1             Out holds an unconsumed word
//   Out_ready  in   1             consumer takes Out this cycle
//   Out_src    out  SEL_W         channel that produced Out
module mux_nway_pipe
    import mux_nway_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [NUM_IN-1:0]       In_valid,
    output logic [NUM_IN-1:0]       In_ready,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    Mode,
    output logic [WIDTH-1:0]        Out,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic [SEL_W-1:0]        Out_src
);

    logic [WIDTH-1:0]  out_p1;
    logic              vld_p1;
    logic [SEL_W-1:0]  src_p1;

    logic              can_load;
    logic [SEL_W-1:0]  gnt;
    logic              gnt_vld;
    logic [NUM_IN-1:0] rdy;
    logic              xfer;
    logic [WIDTH-1:0]  sel_word;

`ifdef MUX_NWAY_ROUND_ROBIN_EN
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_gnt;
    logic              rr_vld;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req     (In_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_gnt),
        .gnt_vld (rr_vld)
    );
`else
    logic unused_mode;
    assign unused_mode = Mode;
`endif

    assign can_load = !vld_p1 || Out_ready;

    // Grant selection: fixed select unless round-robin mode is built and active.
    always_comb begin
        gnt     = Sel;
        gnt_vld = (int'(Sel) < NUM_IN);
`ifdef MUX_NWAY_ROUND_ROBIN_EN
        if (Mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end
`endif
    end

    // Ready goes only to the granted channel and is forced low in reset.
    always_comb begin
        rdy      = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(gnt) == i) begin
                rdy[i]   = Rst_n && can_load && gnt_vld;
                sel_word = In[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer     = |(In_valid & rdy);
    assign In_ready = rdy;

    // ---- stage p1: output register ----
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_p1 <= '0;
            src_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (xfer) begin
            out_p1 <= sel_word;
            src_p1 <= gnt;
            vld_p1 <= 1'b1;
        end else if (Out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef MUX_NWAY_ROUND_ROBIN_EN
    // Pointer starts at the last channel so the first round-robin grant is 0.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rr_ptr <= SEL_W'(NUM_IN - 1);
        end else if (xfer && (Mode == MODE_RR)) begin
            rr_ptr <= gnt;
        end
    end
`endif

    assign Out       = out_p1;
    assign Out_valid = vld_p1;
    assign Out_src   = src_p1;

endmodule

// File: tb/tb_mux_nway_pipe.sv
module tb_mux_nway_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance: 4 x 32-bit
    logic [31:0]  din [4];
    logic [127:0] in_bus;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         mode;
    logic [31:0]  dout;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;

    assign in_bus = {din[3], din[2], din[1], din[0]};

    mux_nway_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In        (in_bus),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Sel       (sel),
        .Mode      (mode),
        .Out       (dout),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .Out_src   (out_src)
    );

    // Second instance: 3 x 16-bit, exercises the out-of-range select
    logic [15:0] bdin [3];
    logic [47:0] b_in_bus;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_sel;
    logic [15:0] b_dout;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_src;

    assign b_in_bus = {bdin[2], bdin[1], bdin[0]};

    mux_nway_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_b (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In        (b_in_bus),
        .In_valid  (b_in_valid),
        .In_ready  (b_in_ready),
        .Sel       (b_sel),
        .Mode      (1'b0),
        .Out       (b_dout),
        .Out_valid (b_out_valid),
        .Out_ready (b_out_ready),
        .Out_src   (b_out_src)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request, check ready before the edge, queue the word if it will transfer.
    task automatic issue(input logic [1:0] s, input logic [3:0] v,
                         input logic [3:0] exp_rdy, input logic [1:0] exp_src);
        sel      = s;
        in_valid = v;
        @(negedge clk);
        chk("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
        if (|(exp_rdy & v)) begin
            q.push_back('{data: din[exp_src], src: exp_src});
        end
        cyc();
    endtask

    // Scoreboard monitor: every accepted output word is checked against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got data=%0h src=%0d, required no output", dout, out_src);
            end else begin
                e = q.pop_front();
                chk("sb_data", {32'd0, dout}, {32'd0, e.data});
                chk("sb_src", {62'd0, out_src}, {62'd0, e.src});
            end
        end
    end

    initial begin
        logic [1:0] rr_a [6];
        logic [1:0] rr_b [4];

        rst_n       = 1'b0;
        mode        = 1'b0;
        sel         = 2'd2;
        out_ready   = 1'b1;
        in_valid    = 4'hF;
        din[0]      = 32'h0000_0010;
        din[1]      = 32'h0000_0011;
        din[2]      = 32'h0000_0012;
        din[3]      = 32'h0000_0013;
        bdin[0]     = 16'h0;
        bdin[1]     = 16'h0;
        bdin[2]     = 16'h0;
        b_sel       = 2'd0;
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;

        // Reset with all valids high
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_out", {32'd0, dout}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_src", {62'd0, out_src}, 64'd0);
        chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
        chk("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        chk("rst_b_in_ready", {61'd0, b_in_ready}, 64'd0);
        cyc();
        rst_n      = 1'b1;
        in_valid   = 4'h0;
        b_in_valid = 3'b000;
        cyc();

        // Fixed select, then back-to-back words at full throughput
        din[2] = 32'hDEAD_BEEF;
        issue(2'd2, 4'b0100, 4'b0100, 2'd2);
        din[0] = 32'hA0A0_A0A0;
        issue(2'd0, 4'b0001, 4'b0001, 2'd0);
        din[1] = 32'hB1B1_B1B1;
        issue(2'd1, 4'b1111, 4'b0010, 2'd1);
        din[3] = 32'hC3C3_C3C3;
        issue(2'd3, 4'b1111, 4'b1000, 2'd3);
        in_valid = 4'h0;
        cyc();
        @(negedge clk);
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_hold_out", {32'd0, dout}, 64'hC3C3_C3C3);
        chk("drain_hold_src", {62'd0, out_src}, 64'd3);
        cyc();

        // Backpressure: held word survives select/data changes
        out_ready = 1'b0;
        din[1]    = 32'h1111_1111;
        issue(2'd1, 4'b0010, 4'b0010, 2'd1);
        for (int k = 0; k < 3; k++) begin
            sel      = 2'(k + 2);
            din[2]   = 32'h2222_0000 + 32'(k);
            in_valid = 4'hF;
            @(negedge clk);
            chk("bp_in_ready", {60'd0, in_ready}, 64'd0);
            chk("bp_out", {32'd0, dout}, 64'h1111_1111);
            chk("bp_src", {62'd0, out_src}, 64'd1);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            cyc();
        end
        out_ready = 1'b1;
        din[2]    = 32'hCAFE_F00D;
        issue(2'd2, 4'hF, 4'b0100, 2'd2);
        in_valid = 4'h0;
        @(negedge clk);
        chk("no_bubble_valid", {63'd0, out_valid}, 64'd1);
        cyc();
        @(negedge clk);
        chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);
        cyc();

        // Out-of-range select on the 3-channel instance
        bdin[0]    = 16'h1234;
        b_sel      = 2'd0;
        b_in_valid = 3'b111;
        @(negedge clk);
        chk("b_in_ready_sel0", {61'd0, b_in_ready}, 64'b001);
        cyc();
        b_sel = 2'd3;
        @(negedge clk);
        chk("b_sel3_in_ready", {61'd0, b_in_ready}, 64'd0);
        chk("b_held_valid", {63'd0, b_out_valid}, 64'd1);
        chk("b_held_out", {48'd0, b_dout}, 64'h1234);
        cyc();
        @(negedge clk);
        chk("b_sel3_drained", {63'd0, b_out_valid}, 64'd0);
        chk("b_sel3_in_ready2", {61'd0, b_in_ready}, 64'd0);
        cyc();
        b_in_valid = 3'b000;

        // Reset while a word is held discards it
        out_ready = 1'b0;
        din[0]    = 32'h5555_AAAA;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        cyc();
        in_valid = 4'b0001;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {60'd0, in_ready}, 64'd0);
        cyc();
        @(negedge clk);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out", {32'd0, dout}, 64'd0);
        rst_n     = 1'b1;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        cyc();

`ifdef MUX_NWAY_ROUND_ROBIN_EN
        // Round-robin: all channels requesting, then gaps
        rr_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_b = '{2'd3, 2'd1, 2'd3, 2'd1};
        din[0] = 32'hA000_0000;
        din[1] = 32'hA000_0001;
        din[2] = 32'hA000_0002;
        din[3] = 32'hA000_0003;
        mode   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            issue(2'd0, 4'b1111, 4'(1) << rr_a[k], rr_a[k]);
        end
        for (int k = 0; k < 4; k++) begin
            issue(2'd0, 4'b1010, 4'(1) << rr_b[k], rr_b[k]);
        end
        for (int k = 0; k < 3; k++) begin
            issue(2'd0, 4'b0010, 4'b0010, 2'd1);
        end
        in_valid = 4'h0;
        mode     = 1'b0;
`else
        rr_a = '{default: 2'd0};
        rr_b = '{default: 2'd0};
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            cyc();
        end
        cyc();
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
